dbus_arbiter: RTL
=================

# dbus_arbiter

Two-master arbiter that shares the single D-bus path into `dbus_interconnect` between the core-0 data port (master 0) and the debug module's system-bus-access port (master 1). It serialises transactions with one outstanding access at a time. It supports locked back-to-back sequences for AMO read-modify-write, and terminates hung slave accesses with a bus-error timeout. It sits between the masters and the D-bus interconnect; all slaves (memory, GPIO, PLIC, CLINT) are reached through it.

## Interface
- `TIMEOUT`, 255: cycles in BUSY without `s_ack` before forced error completion; legal range 1..65535. A 16-bit counter is used.
- `clk` in 1: system clock (divided clock domain).
- `rst_n` in 1: asynchronous active-low reset.
- `m_req` in 2: per-master request. It must hold with its fields stable until that master's `m_ack`.
- `m_lock` in 2: keep ownership after the current transaction completes.
- `m_we` in 2: write enable.
- `m_addr` in 64: master i address at `[32*i +: 32]`.
- `m_wdata` in 64: master i write data at `[32*i +: 32]`.
- `m_wstrb` in 8: master i byte strobes at `[4*i +: 4]`.
- `m_rdata` out 32: read data, broadcast to both masters. It is valid only with `m_ack`.
- `m_ack` out 2: one-cycle completion pulse to the owner.
- `m_err` out 2: error flag, valid only together with `m_ack`.
- `grant` out 2: one-hot current owner, `2'b00` when idle.
- `s_req` out 1: request to the interconnect.
- `s_we` out 1, `s_addr` out 32, `s_wdata` out 32, `s_wstrb` out 4: muxed from the owner.
- `s_rdata` in 32: slave read data.
- `s_ack` in 1: slave completion, single cycle.
- `s_err` in 1: slave error, qualified by `s_ack`.

## Operation
- States: IDLE, BUSY, LOCKED. The owner register is 1 bit plus a valid bit. The RR pointer is 1 bit.
- **IDLE**
  - If any `m_req` is set, select a winner, load the owner, and go to BUSY.
  - Otherwise stay in IDLE.
- **BUSY**
  - `s_req`=1 (registered from state).
  - `s_*` fields are a combinational mux of the owner's inputs.
- **Completion in BUSY**
  - On `s_ack`: `m_ack[owner]`=1 and `m_err[owner]`=`s_err`, both combinational.
  - `m_rdata`=`s_rdata`.
  - Next state is LOCKED if `m_lock[owner]`, else IDLE.
- **Timeout in BUSY**
  - If the counter reaches `TIMEOUT` without `s_ack`: `m_ack[owner]`=1, `m_err[owner]`=1, `m_rdata`=0, next state IDLE.
  - The counter clears on entry to BUSY.
- **LOCKED**
  - `s_req`=0 and ownership is retained.
  - If `m_req[owner]`, go to BUSY with no arbitration.
  - Else if `!m_lock[owner]`, go to IDLE.
  - The other master waits.
- `m_ack`/`m_err` for the non-owner are always 0. `m_rdata`=0 whenever no `m_ack` is asserted.
- Outside BUSY: `s_req`=0 and the `s_*` fields are driven to 0.
- `grant` reflects the owner in BUSY and LOCKED, and is 0 in IDLE.

## Timing
- Reset values: `s_req`=0, `s_we`=0, `s_addr`/`s_wdata`/`s_wstrb`=0, `m_ack`=0, `m_err`=0, `m_rdata`=0, `grant`=0, state IDLE, RR pointer=1.
- Arbitration latency: `m_req` sampled in IDLE at cycle T gives `s_req` high at T+1.
- Completion: `m_ack` is in the same cycle as `s_ack`. The earliest next `s_req` (any master) is 2 cycles after `s_ack` via IDLE, or 2 cycles via LOCKED.
- `s_ack` and timeout in the same cycle: ack wins and `m_err`=`s_err`.
- `s_ack` outside BUSY: ignored, no `m_ack`.
- Owner drops `m_req` before ack: this is a protocol violation. The transaction still completes and `m_ack` still pulses.
- Reset asserted mid-BUSY: all outputs clear immediately (asynchronous). The in-flight slave access is abandoned with no ack generated.

## Configuration
- `DBUS_ARB_RR_EN` defined: round-robin arbitration.
  - On a simultaneous request in IDLE, the master not equal to the RR pointer wins.
  - The pointer updates to the winner at each grant.
  - After reset, master 0 wins the first tie.
- `DBUS_ARB_RR_EN` undefined: fixed priority, and master 1 (debug) always wins a tie. The RR pointer is absent.

## Test plan
- **Single read:** `m_req`=01, `m_addr[31:0]`=`32'h1000_0004`.
  - Required: `s_req` and `s_addr`=`32'h1000_0004` at T+1.
  - Slave acks at T+3 with `s_rdata`=`32'hDEAD_BEEF`: `m_ack`=01, `m_rdata`=`32'hDEAD_BEEF` in that cycle, `grant`=00 at T+4.
- **Tie:** `m_req`=11 in IDLE, three tie rounds.
  - Fixed priority: grants are 10,10,10.
  - With `DBUS_ARB_RR_EN`: grants are 01,10,01.
- **Locked AMO:** master 0 sets `m_lock`=1 for a read then a write while master 1 requests throughout.
  - Required: master 0 completes both transactions before `grant`=10.
  - The write's `s_req` comes 2 cycles after the read ack.
- **Timeout:** `TIMEOUT`=4, no `s_ack`.
  - Required: `m_ack[0]`=1 and `m_err[0]`=1 exactly 4 cycles after `s_req` rises, with `m_rdata`=0.
  - `s_req`=0 the next cycle.
- **Slave error:** `s_ack`=1 with `s_err`=1 on a master 1 write.
  - Required: `m_ack`=10, `m_err`=10, single cycle.
- **Reset in BUSY:** `rst_n` low mid-transaction.
  - Required: `s_req`/`grant`/`m_ack` go to 0 without a clock edge.
  - The first `s_req` after release requires a new `m_req`.

Source files
------------

// File: rtl/dbus_arbiter.sv
// dbus_arbiter: two-master arbiter serialising core-0 data (master 0) and
// debug system-bus access (master 1) onto the single D-bus interconnect path.
// One outstanding access at a time. Locked sequences keep ownership for AMO
// read-modify-write. Hung slave accesses end with a bus-error timeout.
// Optional build macro: DBUS_ARB_RR_EN selects round-robin tie-break.
// When it is undefined, fixed priority is used and master 1 wins ties.
module dbus_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  m_req,
   input  logic [1:0]  m_lock,
   input  logic [1:0]  m_we,
   input  logic [63:0] m_addr,
   input  logic [63:0] m_wdata,
   input  logic [7:0]  m_wstrb,
   output logic [31:0] m_rdata,
   output logic [1:0]  m_ack,
   output logic [1:0]  m_err,
   output logic [1:0]  grant,
   output logic        s_req,
   output logic        s_we,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   input  logic [31:0] s_rdata,
   input  logic        s_ack,
   input  logic        s_err
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY   = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

   state_t      state_q, state_d;
   logic        owner_q, owner_d;
   logic        owner_vld_q, owner_vld_d;
   logic [15:0] tmo_cnt_q, tmo_cnt_d;
   logic        winner;
   logic        tmo_hit;

`ifdef DBUS_ARB_RR_EN
   logic        rr_ptr_q, rr_ptr_d;
`endif

   // A slave ack in the same cycle as the limit takes precedence over the timeout.
   assign tmo_hit = (state_q == ST_BUSY) && !s_ack && (tmo_cnt_q == TIMEOUT_CNT);

   // Pick the winner among the current requesters. A lone requester always wins.
   always_comb begin
      winner = m_req[1];
      if (m_req == 2'b11) begin
`ifdef DBUS_ARB_RR_EN
         winner = ~rr_ptr_q;
`else
         winner = 1'b1;
`endif
      end
   end

   // State, owner, timeout counter and round-robin pointer registers.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before the edge, whatever the statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         owner_q     <= 1'b0;
         owner_vld_q <= 1'b0;
         tmo_cnt_q   <= 16'd0;
`ifdef DBUS_ARB_RR_EN
         rr_ptr_q    <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         owner_vld_q <= owner_vld_d;
         tmo_cnt_q   <= tmo_cnt_d;
`ifdef DBUS_ARB_RR_EN
         rr_ptr_q    <= rr_ptr_d;
`endif
      end
   end

   // Next-state logic: arbitration in IDLE, completion or timeout in BUSY, and
   // lock hold or release in LOCKED.
   // NOTE: every signal assigned here gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      owner_vld_d = owner_vld_q;
      tmo_cnt_d   = tmo_cnt_q;
`ifdef DBUS_ARB_RR_EN
      rr_ptr_d    = rr_ptr_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (|m_req) begin
               state_d     = ST_BUSY;
               owner_d     = winner;
               owner_vld_d = 1'b1;
               tmo_cnt_d   = 16'd0;
`ifdef DBUS_ARB_RR_EN
               rr_ptr_d    = winner;
`endif
            end
         end
         ST_BUSY: begin
            if (s_ack) begin
               if (m_lock[owner_q]) begin
                  state_d = ST_LOCKED;
               end else begin
                  state_d     = ST_IDLE;
                  owner_vld_d = 1'b0;
               end
            end else if (tmo_hit) begin
               state_d     = ST_IDLE;
               owner_vld_d = 1'b0;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 16'd1;
            end
         end
         ST_LOCKED: begin
            if (m_req[owner_q]) begin
               state_d   = ST_BUSY;
               tmo_cnt_d = 16'd0;
            end else if (!m_lock[owner_q]) begin
               state_d     = ST_IDLE;
               owner_vld_d = 1'b0;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            owner_vld_d = 1'b0;
         end
      endcase
   end

   // Output decode: slave-side mux while BUSY, completion routed to the owner only.
   always_comb begin
      s_req   = 1'b0;
      s_we    = 1'b0;
      s_addr  = 32'd0;
      s_wdata = 32'd0;
      s_wstrb = 4'd0;
      m_ack   = 2'b00;
      m_err   = 2'b00;
      m_rdata = 32'd0;
      grant   = 2'b00;
      if (owner_vld_q) begin
         grant[owner_q] = 1'b1;
      end
      if (state_q == ST_BUSY) begin
         s_req   = 1'b1;
         s_we    = m_we[owner_q];
         s_addr  = owner_q ? m_addr[63:32]  : m_addr[31:0];
         s_wdata = owner_q ? m_wdata[63:32] : m_wdata[31:0];
         s_wstrb = owner_q ? m_wstrb[7:4]   : m_wstrb[3:0];
         if (s_ack) begin
            m_ack[owner_q] = 1'b1;
            m_err[owner_q] = s_err;
            m_rdata        = s_rdata;
         end else if (tmo_hit) begin
            m_ack[owner_q] = 1'b1;
            m_err[owner_q] = 1'b1;
         end
      end
   end

endmodule
